// File: rtl/wlan_rx_pkg.sv
// Shared types and constants for the 802.11a RX back end (descrambler to MAC).
package wlan_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVICE,
        DATA
    } rx_state_e;

    localparam int unsigned SERVICE_BITS  = 16;
    localparam int unsigned BYTE_BITS     = 8;
    localparam int unsigned LEN_W_DEFAULT = 12;

endpackage

// File: rtl/rx_bit_packer.sv
// LSB-first serial-to-byte packer: bit_cnt selects the slot for each new bit and
// byte_ready flags the bit that completes a byte, with the full byte on byte_next.
module rx_bit_packer
    import wlan_rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [BYTE_BITS-1:0] byte_next,
    output logic                 byte_ready
);

    localparam int unsigned CNT_W = $clog2(BYTE_BITS);

    logic [CNT_W-1:0]     bit_cnt_q;
    logic [BYTE_BITS-1:0] sr_q;

    // Byte as it will look once the current bit lands, so the completing bit is visible
    // in the same cycle it is accepted.
    always_comb begin
        byte_next            = sr_q;
        byte_next[bit_cnt_q] = bit_in;
    end

    assign byte_ready = shift_en && (bit_cnt_q == CNT_W'(BYTE_BITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            sr_q      <= '0;
        end else if (clear) begin
            bit_cnt_q <= '0;
            sr_q      <= '0;
        end else if (shift_en) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            sr_q      <= byte_next;
        end
    end

endmodule

// File: rtl/rx_psdu_packer.sv
// Strips the 16-bit SERVICE field and packs PSDU bits LSB-first into bytes for the MAC.
// Define SERVICE_CHECK_EN to flag any non-zero SERVICE bit on service_err.
module rx_psdu_packer
    import wlan_rx_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     psdu_len,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [BYTE_BITS-1:0] byte_out,
    output logic                 byte_valid,
    output logic                 byte_last,
    output logic                 done,
    output logic                 busy,
    output logic                 service_err
);

    localparam int unsigned SVC_CNT_W = $clog2(SERVICE_BITS);

    rx_state_e            state_q, state_d;
    logic [SVC_CNT_W-1:0] svc_cnt_q, svc_cnt_d;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     byte_cnt_q, byte_cnt_d, byte_cnt_inc;
    logic                 valid_d, last_d, done_d;
    logic                 shift_en, clear;
    logic [BYTE_BITS-1:0] byte_next;
    logic                 byte_ready;

    rx_bit_packer u_bit_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .shift_en   (shift_en),
        .bit_in     (bit_in),
        .byte_next  (byte_next),
        .byte_ready (byte_ready)
    );

    assign byte_cnt_inc = byte_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        svc_cnt_d  = svc_cnt_q;
        byte_cnt_d = byte_cnt_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        done_d     = 1'b0;
        shift_en   = 1'b0;
        clear      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A bit arriving alongside start belongs to no frame yet.
                if (start) begin
                    state_d    = SERVICE;
                    svc_cnt_d  = '0;
                    byte_cnt_d = '0;
                    clear      = 1'b1;
                end
            end
            SERVICE: begin
                if (bit_valid) begin
                    svc_cnt_d = svc_cnt_q + 1'b1;
                    if (svc_cnt_q == SVC_CNT_W'(SERVICE_BITS - 1)) begin
                        if (len_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                shift_en = bit_valid;
                if (byte_ready) begin
                    valid_d    = 1'b1;
                    byte_cnt_d = byte_cnt_inc;
                    if (byte_cnt_inc == len_q) begin
                        last_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            svc_cnt_q  <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            svc_cnt_q  <= svc_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            byte_valid <= valid_d;
            byte_last  <= last_d;
            done       <= done_d;
            if (state_q == IDLE && start) begin
                len_q <= psdu_len;
            end
            if (valid_d) begin
                byte_out <= byte_next;
            end
        end
    end

    // The state register already drops to IDLE on the edge that raises done.
    assign busy = (state_q != IDLE);

`ifdef SERVICE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            err_q <= 1'b0;
        end else if (state_q == SERVICE && bit_valid && bit_in) begin
            err_q <= 1'b1;
        end
    end

    assign service_err = err_q;
`else
    assign service_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_psdu_packer.sv
// Self-checking bench for rx_psdu_packer: frame table plus reset and overlap sequences.
module tb_rx_psdu_packer;

    localparam int LEN_W = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] psdu_len = '0;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic [7:0]       byte_out;
    logic             byte_valid, byte_last, done, busy, service_err;

    rx_psdu_packer #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .psdu_len    (psdu_len),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_last   (byte_last),
        .done        (done),
        .busy        (busy),
        .service_err (service_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [63:0] data;
        logic [15:0] svc;
        int          max_gap;
        bit          coincide;
        int          pad;
        bit          inject;
    } vec_t;

    vec_t       vecs[7];
    logic [8:0] exp_q[$];  // {last, byte}
    int         n_cmp = 0;
    int         n_err = 0;
    int         done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every byte strobe must match the next expected byte.
    always @(negedge clk) begin
        logic [8:0] e;
        if (done) done_seen++;
        if (byte_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_byte: got 0x%0h with nothing expected at %0t",
                         byte_out, $time);
            end else begin
                e = exp_q.pop_front();
                check("byte_out", {24'h0, byte_out}, {24'h0, e[7:0]});
                check("byte_last", {31'h0, byte_last}, {31'h0, e[8]});
                check("done_with_last", {31'h0, done}, {31'h0, e[8]});
            end
        end
    end

    task automatic send_bit(input logic b, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0;
        bit_valid = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int   d0;
        logic exp_err;
`ifdef SERVICE_CHECK_EN
        exp_err = |v.svc;
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i < v.len; i++) begin
            exp_q.push_back({(i == v.len - 1) ? 1'b1 : 1'b0, v.data[8*i +: 8]});
        end
        d0 = done_seen;
        start    = 1'b1;
        psdu_len = LEN_W'(v.len);
        if (v.coincide) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        bit_valid = 1'b0;
        check("busy_after_start", {31'h0, busy}, 32'h1);
        check("err_cleared_by_start", {31'h0, service_err}, 32'h0);
        for (int i = 0; i < 16; i++) send_bit(v.svc[i], v.max_gap);
        for (int i = 0; i < 8 * v.len; i++) begin
            if (v.inject && i == 12) begin
                start    = 1'b1;
                psdu_len = LEN_W'(1);
            end
            send_bit(v.data[i], v.max_gap);
            start = 1'b0;
        end
        check("done_at_end", {31'h0, done}, 32'h1);
        check("busy_at_end", {31'h0, busy}, 32'h0);
        for (int i = 0; i < v.pad; i++) send_bit(1'($urandom_range(0, 1)), 0);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'h0);
        check("done_count", done_seen - d0, 32'h1);
        check("service_err", {31'h0, service_err}, {31'h0, exp_err});
    endtask

    initial begin
        vec_t r;
        vecs[0] = '{2, 64'hAA01, 16'h0000, 0, 1'b0, 4, 1'b0};
        vecs[1] = '{1, 64'h0F, 16'h0000, 5, 1'b0, 40, 1'b0};
        vecs[2] = '{0, 64'h0, 16'h0000, 0, 1'b0, 3, 1'b0};
        vecs[3] = '{4, 64'h7E5A3CC3, 16'h0000, 2, 1'b0, 0, 1'b1};
        vecs[4] = '{1, 64'h80, 16'h0000, 0, 1'b1, 0, 1'b0};
        vecs[5] = '{1, 64'h5D, 16'h0008, 0, 1'b0, 2, 1'b0};
        vecs[6] = '{8, 64'h0123456789ABCDEF, 16'h0000, 1, 1'b0, 0, 1'b0};

        #12;
        check("rst_byte_out", {24'h0, byte_out}, 32'h0);
        check("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
        check("rst_byte_last", {31'h0, byte_last}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_service_err", {31'h0, service_err}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        // Reset part-way into the first data byte; nothing from that frame may appear.
        start    = 1'b1;
        psdu_len = LEN_W'(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 19; i++) send_bit(1'b1, 0);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_byte_out", {24'h0, byte_out}, 32'h0);
        check("midrst_byte_valid", {31'h0, byte_valid}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_service_err", {31'h0, service_err}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        r = '{1, 64'hC3, 16'h0000, 0, 1'b0, 5, 1'b0};
        run_frame(r);

        check("final_queue_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
